// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int CNT_W = 3;
endpackage

// File: rtl/arb_rr_select.sv
// Combinational winner pick for two requesters; zero latency, no backpressure.
// MEM_ARBITER_FIXED_PRIORITY_EN: m0 wins contention instead of round-robin.
module arb_rr_select
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       locked,
  input  logic       owner,
  output logic       grant_vld,
  output logic       winner
);

`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    grant_vld = |req;
    winner    = M0;
    if (locked && req[owner]) begin
      winner = owner;
    end else if (req == 2'b10) begin
      winner = M1;
    end else if (req == 2'b11) begin
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
      winner = M0;
`else
      winner = ~last;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between m0 and m1 with req/ack handshakes and lock bursts.
// Latency: write ack 2 cycles after the sampling IDLE cycle, read ack read_latency+1.
// Requests are only accepted in IDLE; a req simply waits until the arbiter returns there.
// Arbitration policy switch: MEM_ARBITER_FIXED_PRIORITY_EN (see arb_rr_select).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int addr_width   = 9,
  parameter int read_latency = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [addr_width-1:0] m0_addr,
  input  logic [7:0]            m0_wdata,
  output logic [7:0]            m0_rdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [addr_width-1:0] m1_addr,
  input  logic [7:0]            m1_wdata,
  output logic [7:0]            m1_rdata,
  output logic                  m1_ack,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  input  logic [7:0]            mem_data_out,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(read_latency - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    owner;
  logic                    last;
  logic                    locked;
  logic                    op_we;
  logic                    grant_vld;
  logic                    winner;
  logic                    w_lock;
  logic                    w_we;
  logic [addr_width-1:0]   w_addr;
  logic [7:0]              w_wdata;

  arb_rr_select u_sel (
    .req       ({m1_req, m0_req}),
    .last      (last),
    .locked    (locked),
    .owner     (owner),
    .grant_vld (grant_vld),
    .winner    (winner)
  );

  assign w_lock  = (winner == M1) ? m1_lock  : m0_lock;
  assign w_we    = (winner == M1) ? m1_we    : m0_we;
  assign w_addr  = (winner == M1) ? m1_addr  : m0_addr;
  assign w_wdata = (winner == M1) ? m1_wdata : m0_wdata;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= M0;
      last        <= M1;
      locked      <= 1'b0;
      op_we       <= 1'b0;
      mem_raddr   <= '0;
      mem_waddr   <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m0_ack    <= 1'b0;
          m1_ack    <= 1'b0;
          mem_write <= 1'b0;
          if (grant_vld) begin
            owner  <= winner;
            last   <= winner;
            locked <= w_lock;
            op_we  <= w_we;
            cnt    <= CNT_LOAD;
            if (w_we) begin
              mem_waddr   <= w_addr;
              mem_data_in <= w_wdata;
              mem_write   <= 1'b1;
            end else begin
              mem_raddr <= w_addr;
            end
            state <= ACCESS;
          end else begin
            // no req at all, so the owner has let go of any burst
            locked <= 1'b0;
          end
        end
        ACCESS, WAIT: begin
          mem_write <= 1'b0;
          if (op_we || cnt == '0) begin
            if (!op_we) begin
              if (owner == M1) m1_rdata <= mem_data_out;
              else             m0_rdata <= mem_data_out;
            end
            m0_ack <= (owner == M0);
            m1_ack <= (owner == M1);
            state  <= ACK;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= WAIT;
          end
        end
        ACK: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level arbitration/RAM model feeds expected queues.
module tb_mem_arbiter;
  localparam int RL = 2;
  localparam int AW = 9;

  typedef struct {bit we; bit lock; logic [AW-1:0] addr; logic [7:0] wdata;} tx_t;
  typedef struct {bit mst; bit we; logic [7:0] rdata; int cyc;} exp_t;
  typedef struct {int cyc; bit we; logic [AW-1:0] addr; logic [7:0] dat;} bus_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req = 0, m0_lock = 0, m0_we = 0, m1_req = 0, m1_lock = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [7:0] m0_wdata = '0, m1_wdata = '0;
  logic [7:0] m0_rdata, m1_rdata, mem_data_in, mem_data_out;
  logic m0_ack, m1_ack, mem_write, busy;
  logic [AW-1:0] mem_raddr, mem_waddr;

  logic [7:0] ram [512];
  logic [7:0] mram [512];
  logic [7:0] rd_q;
  bit ram_load = 1'b1;

  tx_t  q0[$], q1[$];
  exp_t exp_q[$];
  bus_t bus_q[$];
  int   errors = 0, checks = 0, cyc = 0;
  bit   sb_en = 1'b0, mw_prev = 1'b0;
  bit   m_last = 1'b1, m_owner = 1'b0, m_locked = 1'b0;

  mem_arbiter #(.addr_width(AW), .read_latency(RL)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM device: one register stage gives data RL=2 cycles after raddr is registered
  assign mem_data_out = rd_q;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int a = 0; a < 512; a++) ram[a] <= mram[a];
    end else if (mem_write) begin
      ram[mem_waddr] <= mem_data_in;
    end
    rd_q <= ram[mem_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Transaction-level reference: spec arbitration rules plus cycle arithmetic per transfer
  task automatic model(input int t0, input int d0, input int d1);
    int t, ack, w;
    int idx[2], avail[2];
    bit p[2];
    tx_t tx;
    t = t0; idx = '{0, 0}; avail[0] = t0 + d0; avail[1] = t0 + d1;
    m_locked = 1'b0;
    while (idx[0] < q0.size() || idx[1] < q1.size()) begin
      p[0] = (idx[0] < q0.size()) && (avail[0] <= t);
      p[1] = (idx[1] < q1.size()) && (avail[1] <= t);
      if (!p[0] && !p[1]) begin
        m_locked = 1'b0;
        t++;
        continue;
      end
      if (m_locked && p[m_owner]) w = m_owner;
      else if (p[0] && !p[1]) w = 0;
      else if (p[1] && !p[0]) w = 1;
      else begin
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
        w = 0;
`else
        w = m_last ? 0 : 1;
`endif
      end
      tx = (w == 1) ? q1[idx[1]] : q0[idx[0]];
      m_owner = w[0]; m_last = w[0]; m_locked = tx.lock;
      ack = t + (tx.we ? 2 : RL + 1);
      if (tx.we) begin
        mram[tx.addr] = tx.wdata;
        bus_q.push_back('{t + 1, 1'b1, tx.addr, tx.wdata});
        exp_q.push_back('{w[0], 1'b1, 8'h00, ack});
      end else begin
        bus_q.push_back('{t + 1, 1'b0, tx.addr, 8'h00});
        exp_q.push_back('{w[0], 1'b0, mram[tx.addr], ack});
      end
      avail[w] = ack + 1;
      idx[w]++;
      t = ack + 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bus_t b;
    bit matched;
    matched = 1'b0;
    if (sb_en) begin
      if (m0_ack || m1_ack) begin
        chk("both_acks", {31'd0, m0_ack & m1_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_master", {31'd0, m1_ack}, {31'd0, e.mst});
          chk("ack_cycle", cyc, e.cyc);
          if (!e.we) chk("rdata", e.mst ? m1_rdata : m0_rdata, e.rdata);
        end
      end
      if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
        b = bus_q.pop_front();
        matched = b.we;
        if (b.we) begin
          chk("mem_write", {31'd0, mem_write}, 32'd1);
          chk("mem_waddr", mem_waddr, b.addr);
          chk("mem_data_in", mem_data_in, b.dat);
        end else begin
          chk("mem_raddr", mem_raddr, b.addr);
        end
      end
      if (mem_write) begin
        if (!matched) chk("mem_write_unexpected", {31'd0, mem_write}, 32'd0);
        chk("mem_write_width", {31'd0, mw_prev}, 32'd0);
      end
    end
    mw_prev = mem_write;
  end

  task automatic run_stream(input int d0, input int d1);
    int t0, i0, i1, n;
    bit a0, a1, done;
    @(posedge clk); #1;
    t0 = cyc;
    model(t0, d0, d1);
    i0 = 0; i1 = 0; a0 = 0; a1 = 0; n = 0; done = 0;
    while (n < 3000) begin
      if (a0) i0++;
      if (a1) i1++;
      if (cyc >= t0 + d0 && i0 < q0.size()) begin
        m0_req = 1; m0_we = q0[i0].we; m0_lock = q0[i0].lock;
        m0_addr = q0[i0].addr; m0_wdata = q0[i0].wdata;
      end else m0_req = 0;
      if (cyc >= t0 + d1 && i1 < q1.size()) begin
        m1_req = 1; m1_we = q1[i1].we; m1_lock = q1[i1].lock;
        m1_addr = q1[i1].addr; m1_wdata = q1[i1].wdata;
      end else m1_req = 0;
      if (i0 == q0.size() && i1 == q1.size()) begin
        done = 1;
        break;
      end
      @(negedge clk); a0 = m0_ack; a1 = m1_ack;
      @(posedge clk); #1;
      n++;
    end
    chk("stream_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("exp_drained", exp_q.size(), 32'd0);
    chk("bus_drained", bus_q.size(), 32'd0);
    exp_q.delete(); bus_q.delete(); q0.delete(); q1.delete();
    m0_req = 0; m1_req = 0;
    repeat (2) @(posedge clk);
  endtask

  function automatic tx_t rand_tx();
    tx_t tx;
    tx.we    = $urandom_range(0, 1) == 1;
    tx.lock  = $urandom_range(0, 2) == 0;
    tx.addr  = ($urandom_range(0, 1) == 1) ? AW'(9'h1F0 + $urandom_range(0, 7)) : AW'($urandom_range(0, 511));
    tx.wdata = 8'($urandom);
    return tx;
  endfunction

  initial begin
    logic [7:0] old;
    int t0;
    for (int a = 0; a < 512; a++) mram[a] = 8'($urandom);
    mram[9'h010] = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_raddr", mem_raddr, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_data_in", mem_data_in, 32'd0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 32'd0);
    ram_load = 0; reset = 0; sb_en = 1;

    q0.push_back('{1'b0, 1'b0, 9'h010, 8'h00});
    run_stream(0, 0);
    q1.push_back('{1'b1, 1'b0, 9'h1FF, 8'h3C});
    run_stream(0, 0);
    chk("ram_1ff", ram[9'h1FF], 32'h3C);

    for (int k = 0; k < 4; k++) begin
      q0.push_back('{1'b0, 1'b0, AW'(9'h020 + k), 8'h00});
      q1.push_back('{1'b0, 1'b0, AW'(9'h030 + k), 8'h00});
    end
    run_stream(0, 0);

    for (int k = 0; k < 4; k++) q1.push_back('{1'b0, k != 3, AW'(9'h100 + k), 8'h00});
    q0.push_back('{1'b0, 1'b0, 9'h010, 8'h00});
    run_stream(1, 0);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 20; k++) begin
        q0.push_back(rand_tx());
        q1.push_back(rand_tx());
      end
      run_stream($urandom_range(0, 3), $urandom_range(0, 3));
    end
    begin
      int bad;
      bad = 0;
      for (int a = 0; a < 512; a++) if (ram[a] !== mram[a]) bad++;
      chk("ram_contents", bad, 32'd0);
    end

    // abandon a read in WAIT with an asynchronous reset
    sb_en = 0;
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_lock = 0; m0_addr = 9'h044; t0 = cyc;
    repeat (2) @(posedge clk); #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1; #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("arst_mem_write", {31'd0, mem_write}, 32'd0);
    m0_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;

    // abandon a write while mem_write is high, before its commit edge
    old = ram[9'h055];
    @(posedge clk); #1;
    m1_req = 1; m1_we = 1; m1_lock = 0; m1_addr = 9'h055; m1_wdata = ~old;
    @(posedge clk); #1;
    chk("pre_rst_write", {31'd0, mem_write}, 32'd1);
    reset = 1; #1;
    chk("arst_write_drop", {31'd0, mem_write}, 32'd0);
    m1_req = 0;
    @(posedge clk); #1;
    chk("ram_not_written", ram[9'h055], old);
    @(negedge clk); reset = 0;
    m_last = 1'b1; m_owner = 1'b0; m_locked = 1'b0;
    sb_en = 1;

    q0.push_back('{1'b0, 1'b0, 9'h055, 8'h00});
    q1.push_back('{1'b1, 1'b0, 9'h056, 8'h77});
    run_stream(0, 0);
    chk("ram_post_rst", ram[9'h056], 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
